alu_sequencer: RTL

//  Issue/control side of the 16-bit ALU. Accepts one instruction word at a time over a

---
 rtl/alu_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Issue/control sequencer for a combinational 16-bit ALU: instruction handshake,
// operand fetch from a 16x16 register file, result capture, write-back and status flags.
module alu_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr_data,
  output logic             instr_ready,
  output logic [3:0]       alu_select,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_result,
  output logic             wb_valid,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_n,
  output logic             div_zero,
  output logic             illegal,
  output logic             halted,
  input  logic [3:0]       dbg_raddr,
  output logic [WIDTH-1:0] dbg_rdata
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_MUL  = 4'b0010, OP_DIV  = 4'b0011,
    OP_AND  = 4'b0100, OP_OR   = 4'b0101, OP_XOR  = 4'b0110, OP_SHL  = 4'b0111,
    OP_SHR  = 4'b1000, OP_IL9  = 4'b1001, OP_ILA  = 4'b1010, OP_MOV  = 4'b1011,
    OP_CMP  = 4'b1100, OP_ILD  = 4'b1101, OP_ILE  = 4'b1110, OP_HALT = 4'b1111
  } op_t;

  state_t           state;
  op_t              ir_op;
  logic [3:0]       ir_rd;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] regs [NREGS];

  op_t              in_op;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] exec_res;
  logic             exec_divz;

  assign dbg_rdata = regs[dbg_raddr];

  always_comb begin
    in_op   = op_t'(instr_data[15:12]);
    rs1_val = regs[instr_data[7:4]];
    rs2_val = (in_op == OP_MOV) ? {{(WIDTH-8){1'b0}}, instr_data[7:0]}
                                : regs[instr_data[3:0]];
  end

  // Divide-by-zero is resolved here rather than trusting whatever the ALU returns.
  always_comb begin
    exec_divz = (ir_op == OP_DIV) && (alu_in1 == '0);
    exec_res  = exec_divz ? '1 : alu_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ir_op       <= OP_ADD;
      ir_rd       <= '0;
      result      <= '0;
      instr_ready <= 1'b1;
      alu_select  <= '0;
      alu_in0     <= '0;
      alu_in1     <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      div_zero    <= 1'b0;
      illegal     <= 1'b0;
      halted      <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            case (in_op)
              OP_IL9, OP_ILA, OP_ILD, OP_ILE: illegal <= 1'b1;
              OP_HALT: begin
                state       <= HALT;
                instr_ready <= 1'b0;
                halted      <= 1'b1;
              end
              default: begin
                state       <= EXEC;
                instr_ready <= 1'b0;
                ir_op       <= in_op;
                ir_rd       <= instr_data[11:8];
                alu_select  <= instr_data[15:12];
                alu_in0     <= rs1_val;
                alu_in1     <= rs2_val;
              end
            endcase
          end
        end
        EXEC: begin
          state      <= WB;
          alu_select <= '0;
          alu_in0    <= '0;
          alu_in1    <= '0;
          result     <= exec_res;
          if (exec_divz) div_zero <= 1'b1;
          if (ir_op != OP_CMP) begin
            wb_valid <= 1'b1;
            wb_addr  <= ir_rd;
            wb_data  <= exec_res;
          end
          if (ir_op != OP_MOV) begin
            flag_z <= (exec_res == '0);
            flag_n <= exec_res[WIDTH-1];
          end
        end
        WB: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          wb_valid    <= 1'b0;
          wb_addr     <= '0;
          wb_data     <= '0;
          if (ir_op != OP_CMP && ir_rd != 4'd0) regs[ir_rd] <= result;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
